cpu_ctrl_fsm: RTL
=================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM for the 16-bit datapath. It sits directly downstream of the
//  instruction decoder. It consumes opcode/ALU_op and sequences register reads, ALU
//  execute and writeback. It drives reg_sel back into the decoder's Rn/Rd/Rm select mux.
//  Accepts one instruction per start handshake and returns to idle (waiting=1) when done.
// PARAMETERS
//  SEL_RN   2'b10  reg_sel code selecting Rn (decoder mux encoding)
//  SEL_RD   2'b01  reg_sel code selecting Rd
//  SEL_RM   2'b00  reg_sel code selecting Rm
//  WB_C     2'b00  wb_sel code: regfile write data = ALU/shifter result register C
//  WB_IMM   2'b10  wb_sel code: regfile write data = sximm8
// PORTS
//  clk        in   1  single clock, all state updates on rising edge
//  rst        in   1  reset, synchronous, active-high
//  start      in   1  request to execute instruction presented on opcode/ALU_op
//  opcode     in   3  from decoder, ir[15:13]; sampled only on accept
//  ALU_op     in   2  from decoder, ir[12:11]; sampled only on accept
//  waiting    out  1  1 = idle, start will be accepted
//  reg_sel    out  2  Rn/Rd/Rm select to decoder (drives r_addr/w_addr)
//  wb_sel     out  2  regfile write-data source select
//  w_en       out  1  regfile write strobe
//  en_A       out  1  load operand register A
//  en_B       out  1  load operand register B
//  en_C       out  1  load result register C
//  en_status  out  1  load Z/N/V status register
//  sel_A      out  1  1 = ALU A input forced to 16'd0 (MOV reg, MVN)
//  bad_instr  out  1  1-cycle pulse: accepted instruction is unsupported, nothing executed
// BEHAVIOUR
//  - Moore FSM: all outputs decoded from registered state + latched op; no comb path in->out.
//  - States: WAIT, DEC, LOAD_A, LOAD_B, EXEC, WB_REG, WB_IMM.
//  - Accept: WAIT & start on a rising edge -> latch {opcode,ALU_op} -> DEC. start ignored elsewhere.
//  - DEC classifies the latched op:
//      110/10 MOV Rn,#imm8 -> WB_IMM; 110/00 MOV Rd,Rm{,sh} -> LOAD_B; 101/11 MVN -> LOAD_B
//      101/00 ADD, 101/01 CMP, 101/10 AND -> LOAD_A; anything else -> WAIT, bad_instr=1 in DEC
//  - LOAD_A: reg_sel=SEL_RN, en_A=1 -> LOAD_B.
//  - LOAD_B: reg_sel=SEL_RM, en_B=1 -> EXEC.
//  - EXEC: sel_A=1 for MOV-reg/MVN else 0. CMP: en_status=1, en_C=0 -> WAIT.
//      Others: en_C=1 -> WB_REG. ADD/AND/MVN also assert en_status; MOV-reg does not.
//  - WB_REG: reg_sel=SEL_RD, wb_sel=WB_C, w_en=1 -> WAIT.
//  - WB_IMM: reg_sel=SEL_RN, wb_sel=WB_IMM, w_en=1 -> WAIT.
//  - Idle/default output values: waiting=1 only in WAIT.
//      reg_sel=SEL_RM, wb_sel=WB_C, all strobes and sel_A and bad_instr = 0.
//  - Latency, start-accept edge to waiting=1 again: MOV imm 3, bad 2, MOV reg/MVN/CMP 5, ADD/AND 6.
//  - Exactly one w_en cycle per writing instruction; never for CMP or bad instructions.
//  - Reset: rst=1 at an edge -> state WAIT, latched op cleared to 0, regardless of state.
//      rst has priority over start on the same edge.
//      Mid-instruction reset aborts with no further strobes; w_en=0 from the cycle after the edge.
//  - start held high continuously: a new instruction is accepted on each edge where waiting=1.
//      This is back-to-back with 0 idle cycles beyond WAIT.
//  - Unreachable state encodings recover to WAIT on the next edge.
// TESTING
//  1 rst high 2 cycles, start=1 -> waiting=1, all strobes 0, no accept while rst=1.
//  2 MOV imm (110/10), start 1 cycle -> DEC, WB_IMM (w_en=1, reg_sel=10, wb_sel=10); waiting at +3.
//  3 ADD (101/00) -> en_A (sel 10), en_B (sel 00), en_C+en_status, w_en (sel 01); exactly 1 w_en; waiting at +6.
//  4 CMP (101/01) -> en_status=1 in EXEC, en_C=0, no w_en; waiting at +5.
//      MVN -> sel_A=1 in EXEC.
//  5 opcode 111 -> bad_instr=1 one cycle in DEC, no strobes, waiting at +2.
//      Change opcode during ADD -> sequence unchanged.
//  6 rst asserted in LOAD_B of ADD -> next cycle WAIT, no en_C/w_en.
//      start held high -> two MOV imm back-to-back, w_en pulses 3 cycles apart.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit datapath.
// Accepts one decoded instruction per start handshake, then sequences the
// operand reads, the ALU execute step and the register writeback.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_WAIT   | idle, waiting=1, start latches {opcode, alu_op}
//  S_DEC    | classify latched op; unsupported ops pulse bad_instr here
//  S_LOAD_A | read Rn into operand register A
//  S_LOAD_B | read Rm into operand register B
//  S_EXEC   | ALU/shifter result into C and/or flags into status
//  S_WB_REG | write C back to Rd
//  S_WB_IMM | write sximm8 to Rn
module cpu_ctrl_fsm #(
    parameter logic [1:0] SEL_RN = 2'b10,
    parameter logic [1:0] SEL_RD = 2'b01,
    parameter logic [1:0] SEL_RM = 2'b00,
    parameter logic [1:0] WB_C   = 2'b00,
    parameter logic [1:0] WB_IMM = 2'b10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] alu_op_i,
    output logic       waiting_o,
    output logic [1:0] reg_sel_o,
    output logic [1:0] wb_sel_o,
    output logic       w_en_o,
    output logic       en_a_o,
    output logic       en_b_o,
    output logic       en_c_o,
    output logic       en_status_o,
    output logic       sel_a_o,
    output logic       bad_instr_o
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DEC    = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_EXEC   = 3'd4,
        S_WB_REG = 3'd5,
        S_WB_IMM = 3'd6
    } state_t;

    localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
    localparam logic [4:0] OP_MOV_REG = 5'b110_00;
    localparam logic [4:0] OP_ADD     = 5'b101_00;
    localparam logic [4:0] OP_CMP     = 5'b101_01;
    localparam logic [4:0] OP_AND     = 5'b101_10;
    localparam logic [4:0] OP_MVN     = 5'b101_11;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;

    // State and latched-instruction registers; reset wins over any accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_WAIT;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state and Moore output decode from registered state and latched op only.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        waiting_o   = 1'b0;
        reg_sel_o   = SEL_RM;
        wb_sel_o    = WB_C;
        w_en_o      = 1'b0;
        en_a_o      = 1'b0;
        en_b_o      = 1'b0;
        en_c_o      = 1'b0;
        en_status_o = 1'b0;
        sel_a_o     = 1'b0;
        bad_instr_o = 1'b0;

        case (state_q)
            S_WAIT: begin
                waiting_o = 1'b1;
                if (start_i) begin
                    op_d    = {opcode_i, alu_op_i};
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                case (op_q)
                    OP_MOV_IMM:             state_d = S_WB_IMM;
                    OP_MOV_REG, OP_MVN:     state_d = S_LOAD_B;
                    OP_ADD, OP_CMP, OP_AND: state_d = S_LOAD_A;
                    default: begin
                        bad_instr_o = 1'b1;
                        state_d     = S_WAIT;
                    end
                endcase
            end
            S_LOAD_A: begin
                reg_sel_o = SEL_RN;
                en_a_o    = 1'b1;
                state_d   = S_LOAD_B;
            end
            S_LOAD_B: begin
                reg_sel_o = SEL_RM;
                en_b_o    = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                // MOV-reg and MVN have no A operand, so the ALU sees zero there.
                sel_a_o = (op_q == OP_MOV_REG) || (op_q == OP_MVN);
                if (op_q == OP_CMP) begin
                    en_status_o = 1'b1;
                    state_d     = S_WAIT;
                end else begin
                    en_c_o      = 1'b1;
                    en_status_o = (op_q != OP_MOV_REG);
                    state_d     = S_WB_REG;
                end
            end
            S_WB_REG: begin
                reg_sel_o = SEL_RD;
                wb_sel_o  = WB_C;
                w_en_o    = 1'b1;
                state_d   = S_WAIT;
            end
            S_WB_IMM: begin
                reg_sel_o = SEL_RN;
                wb_sel_o  = WB_IMM;
                w_en_o    = 1'b1;
                state_d   = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule
